// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS-style front end:
//   - RESET_PC_DEFAULT : PC value loaded on reset unless overridden
//   - OP_* / FUNCT_JR  : opcode field (Instruction[31:26]) and jr funct values
//   - fetch_state_t    : fetch FSM state encoding
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Primary opcode field values (Instruction[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // funct field (Instruction[5:0]) of an R-type jr.
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_select.sv
// ---------------------------------------------------------------------------
// next_pc_select
// Purely combinational next-PC selection for the fetch unit.
// Ports:
//   pc_plus4        in  32  address after the current instruction
//   jump_register   in   1  jr: target comes from a register
//   jump            in   1  j/jal: 26-bit pseudo-direct target
//   branch, zero    in   1  beq taken when both are high
//   branch_offset   in  32  sign-extended word offset
//   jump_target     in  26  Instruction[25:0]
//   register_target in  32  rs value for jr
//   next_pc         out 32  selected next PC (always word aligned)
//   addr_misaligned out  1  jr target has non-zero low bits
// ---------------------------------------------------------------------------
module next_pc_select (
    input  logic [31:0] pc_plus4,
    input  logic        jump_register,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] register_target,
    output logic [31:0] next_pc,
    output logic        addr_misaligned
);

    // Priority: jr > j/jal > taken branch > sequential. All additions wrap
    // naturally at 32 bits.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_register) begin
            // Low bits are forced to zero; the misalignment is reported
            // separately rather than trapping.
            next_pc = {register_target[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + (branch_offset << 2);
        end
    end

    assign addr_misaligned = jump_register && (register_target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Three-state fetch engine (IDLE -> FETCH -> VALID -> FETCH ...). Holds the
// PC and the fetched instruction, requests words from instruction memory,
// and advances the PC when downstream retires the instruction.
// Ports:
//   clk, reset        in        clock, synchronous active-high reset
//   ImemReq/ImemAddr  out 1/32  fetch request and address (== PC)
//   ImemReady/Data    in  1/32  memory response strobe and word
//   Instruction       out 32    registered fetched word
//   InstrValid        out 1     Instruction is fetched and not yet retired
//   PC, PCPlus4       out 32    current PC and PC+4 (jal link value)
//   Jump, Branch, JumpRegister, Zero, BranchOffset, JumpTarget,
//   RegisterTarget    in        decode/ALU controls, sampled at retire only
//   Stall             in  1     downstream not ready to retire
//   AddrError         out 1     misaligned jr target taken this cycle
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        JumpRegister,
    input  logic        Zero,
    input  logic [31:0] BranchOffset,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] RegisterTarget,
    input  logic        Stall,
    output logic        AddrError
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  instr_reg;
    logic         imem_req_reg;
    logic         instr_valid_reg;

    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         addr_misaligned;
    logic         retire;

    assign pc_plus4 = pc_reg + 32'd4;

    // Controls are only meaningful while an instruction is held and being
    // retired; outside that window they may be don't-care from the decoder.
    assign retire = (state_reg == ST_VALID) && !Stall;

    next_pc_select u_next_pc_select (
        .pc_plus4        (pc_plus4),
        .jump_register   (JumpRegister),
        .jump            (Jump),
        .branch          (Branch),
        .zero            (Zero),
        .branch_offset   (BranchOffset),
        .jump_target     (JumpTarget),
        .register_target (RegisterTarget),
        .next_pc         (next_pc),
        .addr_misaligned (addr_misaligned)
    );

    // ImemReq / InstrValid are registered alongside the state so they are
    // glitch-free decodes of FETCH / VALID respectively.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= 32'h0;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg    <= ST_FETCH;
                    imem_req_reg <= 1'b1;
                end
                ST_FETCH: begin
                    if (ImemReady) begin
                        instr_reg       <= ImemData;
                        state_reg       <= ST_VALID;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (!Stall) begin
                        pc_reg          <= next_pc;
                        state_reg       <= ST_FETCH;
                        imem_req_reg    <= 1'b1;
                        instr_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    imem_req_reg    <= 1'b0;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ImemReq     = imem_req_reg;
    assign ImemAddr    = pc_reg;
    assign Instruction = instr_reg;
    assign InstrValid  = instr_valid_reg;
    assign PC          = pc_reg;
    assign PCPlus4     = pc_plus4;

    // Asserted during the retire cycle itself; reset suppresses it because
    // reset wins over a simultaneous retire.
    assign AddrError   = !reset && retire && addr_misaligned;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Self-checking bench: reset checks, hand-written multi-cycle sequences,
// a table of next-PC vectors, and a randomized instruction stream checked
// against a transaction-level PC model.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Jump;
    logic        Branch;
    logic        JumpRegister;
    logic        Zero;
    logic [31:0] BranchOffset;
    logic [25:0] JumpTarget;
    logic [31:0] RegisterTarget;
    logic        Stall;
    logic        AddrError;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ImemReq        (ImemReq),
        .ImemAddr       (ImemAddr),
        .ImemReady      (ImemReady),
        .ImemData       (ImemData),
        .Instruction    (Instruction),
        .InstrValid     (InstrValid),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .Jump           (Jump),
        .Branch         (Branch),
        .JumpRegister   (JumpRegister),
        .Zero           (Zero),
        .BranchOffset   (BranchOffset),
        .JumpTarget     (JumpTarget),
        .RegisterTarget (RegisterTarget),
        .Stall          (Stall),
        .AddrError      (AddrError)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        jr;
        logic        j;
        logic        br;
        logic        z;
        logic [31:0] off;
        logic [25:0] jt;
        logic [31:0] rt;
        logic [31:0] exp_next;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic controls_x();
        Jump           = 1'bx;
        Branch         = 1'bx;
        JumpRegister   = 1'bx;
        Zero           = 1'bx;
        BranchOffset   = 'x;
        JumpTarget     = 'x;
        RegisterTarget = 'x;
    endtask

    task automatic controls_rand();
        Jump           = 1'($urandom);
        Branch         = 1'($urandom);
        JumpRegister   = 1'($urandom);
        Zero           = 1'($urandom);
        BranchOffset   = $urandom;
        JumpTarget     = 26'($urandom);
        RegisterTarget = $urandom;
    endtask

    // Bounded wait for a fetch request.
    task automatic wait_req();
        int k = 0;
        while (ImemReq !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("wait_req", {31'b0, ImemReq}, 32'd1);
    endtask

    // Answer the outstanding request after 'delay' idle cycles.
    task automatic fetch(input logic [31:0] data, input int delay);
        for (int i = 0; i < delay; i++) begin
            ImemReady = 1'b0;
            ImemData  = $urandom;
            tick();
            chk("req_held", {31'b0, ImemReq}, 32'd1);
            chk("valid_low_in_fetch", {31'b0, InstrValid}, 32'd0);
        end
        ImemReady = 1'b1;
        ImemData  = data;
        tick();
        ImemReady = 1'b0;
        ImemData  = $urandom;
        chk("instr_valid", {31'b0, InstrValid}, 32'd1);
        chk("instruction", Instruction, data);
        chk("req_dropped", {31'b0, ImemReq}, 32'd0);
    endtask

    // Retire the held instruction with the given controls.
    task automatic retire(input logic jr, input logic j, input logic br, input logic z,
                          input logic [31:0] off, input logic [25:0] jt, input logic [31:0] rt,
                          input logic [31:0] exp_next, input logic exp_err);
        Stall          = 1'b0;
        JumpRegister   = jr;
        Jump           = j;
        Branch         = br;
        Zero           = z;
        BranchOffset   = off;
        JumpTarget     = jt;
        RegisterTarget = rt;
        #1;
        chk("addr_error", {31'b0, AddrError}, {31'b0, exp_err});
        tick();
        Stall = 1'b1;
        controls_x();
        #1;
        chk("addr_error_pulse_end", {31'b0, AddrError}, 32'd0);
        chk("refetch_req", {31'b0, ImemReq}, 32'd1);
        chk("next_pc", ImemAddr, exp_next);
    endtask

    // Transaction-level model: next PC from the current PC and controls.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic jr, input logic j,
                                               input logic br, input logic z, input logic [31:0] off,
                                               input logic [25:0] jt, input logic [31:0] rt);
        logic [31:0] seq = pc + 32'd4;
        if (jr) return rt & 32'hFFFF_FFFC;
        if (j) return (seq & 32'hF000_0000) | (32'(jt) * 32'd4);
        if (br && z) return seq + off * 32'd4;
        return seq;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] model_pc;
        logic [31:0] data;
        logic        jr, j, br, z, exp_err;
        logic [31:0] off, rt, exp_next;
        logic [25:0] jt;

        vecs[0] = '{"beq_back",   32'h0000_0100, 0, 0, 1, 1, 32'hFFFF_FFFE, 26'h0,       32'h0,         32'h0000_00FC, 0};
        vecs[1] = '{"j_over_beq", 32'h0040_0010, 0, 1, 1, 1, 32'h0000_0010, 26'h0000040, 32'h0,         32'h0000_0100, 0};
        vecs[2] = '{"jr_misal",   32'h0000_0300, 1, 0, 0, 0, 32'h0,         26'h0,       32'h0000_0203, 32'h0000_0200, 1};
        vecs[3] = '{"beq_nt",     32'h0000_0200, 0, 0, 1, 0, 32'h0000_0010, 26'h0,       32'h0,         32'h0000_0204, 0};
        vecs[4] = '{"seq_wrap",   32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0,         26'h0,       32'h0,         32'h0000_0000, 0};
        vecs[5] = '{"jr_over_j",  32'h0000_1000, 1, 1, 0, 0, 32'h0,         26'h3FFFFFF, 32'h8000_0010, 32'h8000_0010, 0};
        vecs[6] = '{"beq_fwd",    32'h0000_0040, 0, 0, 1, 1, 32'h0000_0003, 26'h0,       32'h0,         32'h0000_0050, 0};
        vecs[7] = '{"j_region",   32'hF000_0000, 0, 1, 0, 0, 32'h0,         26'h2AAAAAA, 32'h0,         32'hFAAA_AAA8, 0};
        vecs[8] = '{"beq_wrap",   32'hFFFF_FFF8, 0, 0, 1, 1, 32'h0000_0002, 26'h0,       32'h0,         32'h0000_0004, 0};
        vecs[9] = '{"jr_misal_top", 32'h0000_0010, 1, 0, 0, 0, 32'h0,       26'h0,       32'hFFFF_FFFF, 32'hFFFF_FFFC, 1};

        // ---------------- reset values ----------------
        reset     = 1'b1;
        ImemReady = 1'b0;
        ImemData  = 32'h0;
        Stall     = 1'b1;
        controls_x();
        tick(); tick(); tick();
        chk("rst_imemreq", {31'b0, ImemReq}, 32'd0);
        chk("rst_valid", {31'b0, InstrValid}, 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_addrerr", {31'b0, AddrError}, 32'd0);
        chk("rst_pcplus4", PCPlus4, 32'h4);

        // ---------------- first fetch at full rate ----------------
        reset = 1'b0;
        chk("idle_no_req", {31'b0, ImemReq}, 32'd0);
        tick();
        chk("first_req", {31'b0, ImemReq}, 32'd1);
        chk("first_addr", ImemAddr, 32'h0);
        fetch(32'h8C01_0004, 0);

        // ---------------- stall holds everything ----------------
        for (int i = 0; i < 3; i++) begin
            ImemReady = 1'b1;            // ignored outside FETCH
            ImemData  = $urandom;
            controls_rand();             // ignored while stalled
            tick();
            chk("stall_pc", PC, 32'h0);
            chk("stall_instr", Instruction, 32'h8C01_0004);
            chk("stall_req", {31'b0, ImemReq}, 32'd0);
            chk("stall_valid", {31'b0, InstrValid}, 32'd1);
        end
        ImemReady = 1'b0;
        retire(0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 32'h4, 0);

        // ---------------- table of next-PC vectors ----------------
        foreach (vecs[v]) begin
            wait_req();
            fetch($urandom, 0);
            retire(1, 0, 0, 0, 32'h0, 26'h0, vecs[v].pc, vecs[v].pc, 0);
            fetch($urandom, 1);
            $display("vector %s", vecs[v].name);
            retire(vecs[v].jr, vecs[v].j, vecs[v].br, vecs[v].z, vecs[v].off,
                   vecs[v].jt, vecs[v].rt, vecs[v].exp_next, vecs[v].exp_err);
        end

        // ---------------- reset mid-FETCH with ImemReady ----------------
        wait_req();
        ImemReady = 1'b1;
        ImemData  = 32'hDEAD_BEEF;
        reset     = 1'b1;
        tick();
        chk("rstf_instr", Instruction, 32'h0);
        chk("rstf_pc", PC, 32'h0);
        chk("rstf_req", {31'b0, ImemReq}, 32'd0);
        chk("rstf_valid", {31'b0, InstrValid}, 32'd0);
        reset = 1'b0;                    // late ready still high in IDLE
        tick();
        ImemReady = 1'b0;
        chk("late_ready_valid", {31'b0, InstrValid}, 32'd0);
        chk("late_ready_instr", Instruction, 32'h0);
        chk("restart_req", {31'b0, ImemReq}, 32'd1);
        chk("restart_addr", ImemAddr, 32'h0);

        // ---------------- reset beats retire ----------------
        fetch(32'h1234_5678, 0);
        Stall          = 1'b0;
        JumpRegister   = 1'b1;
        Jump           = 1'b0;
        Branch         = 1'b0;
        Zero           = 1'b0;
        RegisterTarget = 32'h0000_0555;
        reset          = 1'b1;
        #1;
        chk("rst_retire_addrerr", {31'b0, AddrError}, 32'd0);
        tick();
        Stall = 1'b1;
        controls_x();
        chk("rst_retire_pc", PC, 32'h0);
        chk("rst_retire_valid", {31'b0, InstrValid}, 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- randomized stream vs. model ----------------
        model_pc = 32'h0;
        for (int n = 0; n < 150; n++) begin
            wait_req();
            chk("rnd_addr", ImemAddr, model_pc);
            data = $urandom;
            fetch(data, int'($urandom_range(0, 3)));
            chk("rnd_pc", PC, model_pc);
            chk("rnd_pcplus4", PCPlus4, model_pc + 32'd4);
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                controls_rand();
                ImemReady = 1'($urandom);
                tick();
                ImemReady = 1'b0;
                chk("rnd_stall_instr", Instruction, data);
                chk("rnd_stall_pc", PC, model_pc);
            end
            jr  = ($urandom_range(0, 5) == 0);
            j   = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 2) == 0);
            z   = 1'($urandom);
            off = $urandom_range(0, 1) ? (32'($urandom_range(0, 64)) - 32'd32) : $urandom;
            jt  = 26'($urandom);
            rt  = $urandom;
            exp_next = model_next(model_pc, jr, j, br, z, off, jt, rt);
            exp_err  = jr && (rt % 4 != 0);
            retire(jr, j, br, z, off, jt, rt, exp_next, exp_err);
            model_pc = exp_next;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
